// File: rtl/comparator_pkg.sv
// Shared width default and compare-result encoding for the comparator slice.
package comparator_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_result_e;

endpackage

// File: rtl/comparator_core.sv
// Combinational magnitude compare and absolute difference in signed or unsigned mode.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_e      result,
    output logic [WIDTH-1:0] abs_diff
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] diff_ext;

    // One extra bit lets a single signed compare serve both modes: sign-extend
    // in signed mode, zero-extend in unsigned mode.
    always_comb begin
        a_ext    = {is_signed & a[WIDTH-1], a};
        b_ext    = {is_signed & b[WIDTH-1], b};
        result   = CMP_EQ;
        diff_ext = '0;
        if (a_ext == b_ext) begin
            result   = CMP_EQ;
            diff_ext = '0;
        end else if ($signed(a_ext) < $signed(b_ext)) begin
            result   = CMP_LT;
            diff_ext = b_ext - a_ext;
        end else begin
            result   = CMP_GT;
            diff_ext = a_ext - b_ext;
        end
    end

    // The ordered subtraction never sets the top bit; folding it in saturates instead of wrapping.
    assign abs_diff = diff_ext[WIDTH-1:0] | {WIDTH{diff_ext[WIDTH]}};

endmodule

// File: rtl/comparator.sv
// Registered comparator: qualifies inputs, decodes the core result to one-hot flags, holds results.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int SIGNED_DEFAULT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [WIDTH-1:0] diff
);

    if (WIDTH < 1 || WIDTH > 64 || SIGNED_DEFAULT < 0 || SIGNED_DEFAULT > 1) begin : g_bad_param
        $error("comparator: WIDTH must be 1..64 and SIGNED_DEFAULT 0 or 1");
    end

    cmp_result_e      core_result;
    logic [WIDTH-1:0] core_diff;

    logic             out_valid_d, out_valid_q;
    logic             lt_d, lt_q;
    logic             eq_d, eq_q;
    logic             gt_d, gt_q;
    logic [WIDTH-1:0] diff_d, diff_q;

    comparator_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .result   (core_result),
        .abs_diff (core_diff)
    );

    // Results load only on a sampled transaction and otherwise hold.
    always_comb begin
        out_valid_d = in_valid;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        diff_d      = diff_q;
        if (in_valid) begin
            lt_d   = (core_result == CMP_LT);
            eq_d   = (core_result == CMP_EQ);
            gt_d   = (core_result == CMP_GT);
            diff_d = core_diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            diff_q      <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            diff_q      <= diff_d;
        end
    end

    assign out_valid = out_valid_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign diff      = diff_q;

endmodule

// File: tb/tb_comparator.sv
// Directed self-checking bench for comparator at WIDTH=8.
module tb_comparator;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             is_signed;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             lt;
    logic             eq;
    logic             gt;
    logic [WIDTH-1:0] diff;

    int tests_run    = 0;
    int tests_failed = 0;

    comparator #(
        .WIDTH(WIDTH),
        .SIGNED_DEFAULT(0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .is_signed(is_signed),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .lt       (lt),
        .eq       (eq),
        .gt       (gt),
        .diff     (diff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one input cycle at the falling edge, away from the sampling edge.
    task automatic applyStimulus(input logic v, input logic s, input logic [WIDTH-1:0] va,
                                 input logic [WIDTH-1:0] vb);
        @(negedge clk);
        in_valid  = v;
        is_signed = s;
        a         = va;
        b         = vb;
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic elt, input logic eeq,
                            input logic egt, input logic [WIDTH-1:0] ediff);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
        checkOutput({tag, ".lt"}, 64'(lt), 64'(elt));
        checkOutput({tag, ".eq"}, 64'(eq), 64'(eeq));
        checkOutput({tag, ".gt"}, 64'(gt), 64'(egt));
        checkOutput({tag, ".diff"}, 64'(diff), 64'(ediff));
    endtask

    task automatic runVector(input string tag, input logic s, input logic [WIDTH-1:0] va,
                             input logic [WIDTH-1:0] vb, input logic elt, input logic eeq,
                             input logic egt, input logic [WIDTH-1:0] ediff);
        applyStimulus(1'b1, s, va, vb);
        @(posedge clk);
        #1;
        checkAll(tag, 1'b1, elt, eeq, egt, ediff);
    endtask

    // Reference: operands as plain integers, difference by absolute value.
    function automatic void refModel(input logic s, input logic [WIDTH-1:0] va,
                                     input logic [WIDTH-1:0] vb, output logic elt,
                                     output logic eeq, output logic egt,
                                     output logic [WIDTH-1:0] ediff);
        int ia;
        int ib;
        int d;
        ia    = s ? int'($signed(va)) : int'({24'b0, va});
        ib    = s ? int'($signed(vb)) : int'({24'b0, vb});
        d     = (ia > ib) ? ia - ib : ib - ia;
        elt   = (ia < ib);
        eeq   = (va == vb);
        egt   = (ia > ib);
        ediff = d[WIDTH-1:0];
    endfunction

    initial begin
        logic             elt, eeq, egt;
        logic [WIDTH-1:0] ediff;
        logic [WIDTH-1:0] ra, rb;
        logic             rs;

        rst       = 1'b1;
        in_valid  = 1'b1;
        is_signed = 1'b0;
        a         = 8'h12;
        b         = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;

        runVector("u_05_0a", 1'b0, 8'h05, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h05);
        runVector("u_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'hFE);
        runVector("s_ff_01", 1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0, 8'h02);
        runVector("s_80_7f", 1'b1, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 8'hFF);
        runVector("u_80_7f", 1'b0, 8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 8'h01);
        runVector("s_7f_80", 1'b1, 8'h7F, 8'h80, 1'b0, 1'b0, 1'b1, 8'hFF);
        runVector("s_fe_fd", 1'b1, 8'hFE, 8'hFD, 1'b0, 1'b0, 1'b1, 8'h01);

        runVector("eq_3c", 1'b1, 8'h3C, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, ~is_signed, 8'hA5 ^ 8'(i), 8'h11);
            @(posedge clk);
            #1;
            checkAll($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        end

        elt = 1'b0; eeq = 1'b0; egt = 1'b0; ediff = '0;
        for (int i = 0; i < 25; i++) begin
            ra = WIDTH'($urandom);
            rb = (i % 7 == 3) ? ra : WIDTH'($urandom);
            rs = 1'(($urandom >> 3) & 1);
            @(negedge clk);
            rst       = (i == 9);
            in_valid  = 1'b1;
            is_signed = rs;
            a         = ra;
            b         = rb;
            @(posedge clk);
            #1;
            if (i == 9) begin
                elt = 1'b0; eeq = 1'b0; egt = 1'b0; ediff = '0;
                checkAll("rnd_rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
            end else begin
                refModel(rs, ra, rb, elt, eeq, egt, ediff);
                checkAll($sformatf("rnd%0d", i), 1'b1, elt, eeq, egt, ediff);
                checkOutput($sformatf("rnd%0d.onehot", i), 64'(int'(lt) + int'(eq) + int'(gt)), 64'd1);
            end
        end
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 8'h00, 8'hFF);
        @(posedge clk);
        #1;
        checkAll("tail_hold", 1'b0, elt, eeq, egt, ediff);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/comparator.md
COMPARATOR -- requirements
Module: comparator

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; legal range 1..64.
REQ-002 Parameter SIGNED_DEFAULT, default 0: reserved constant; the runtime mode is set by the is_signed port only.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  a, b and is_signed are sampled on a clock edge when this is high.
REQ-006 is_signed  input  1  1 = two's-complement compare; 0 = unsigned compare.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 out_valid  output  1  the result registers hold a new result this cycle.
REQ-010 lt  output  1  registered flag: a < b.
REQ-011 eq  output  1  registered flag: a == b.
REQ-012 gt  output  1  registered flag: a > b.
REQ-013 diff  output  WIDTH  registered |a - b|, interpreted in the selected mode, unsigned result.

Function
REQ-014 Latency: sample on edge N with in_valid=1; lt, eq, gt, diff and out_valid are updated on edge N+1 (one cycle); results are registered, not combinational.
REQ-015 Throughput: one compare per cycle; back-to-back in_valid produces back-to-back out_valid; no backpressure.
REQ-016 out_valid equals in_valid delayed one cycle; when in_valid=0, out_valid=0 next cycle.
REQ-017 While out_valid=0, lt, eq, gt and diff hold their last values.
REQ-018 Whenever the flags have been loaded since reset, exactly one of lt, eq and gt is 1 (one-hot).
REQ-019 Unsigned mode: a and b are compared as 0..2^WIDTH-1.
REQ-020 Signed mode: the MSB is the sign bit and the range is -2^(WIDTH-1)..2^(WIDTH-1)-1.
REQ-021 eq depends on bit equality only and is independent of is_signed.
REQ-022 diff is computed at WIDTH+1 bits internally, then truncated to WIDTH.
REQ-023 The signed extreme case (most-negative versus most-positive) yields 2^WIDTH-1 and does not wrap.
REQ-024 Mode may change on every sampled transaction; no mode state is retained.
REQ-025 X or Z on a or b when in_valid=0 has no effect.

Reset
REQ-026 When rst=1 at a clock edge, out_valid, lt, eq, gt and diff all become 0 on that edge.
REQ-027 rst has priority over in_valid; a transaction sampled in the same cycle as rst is discarded.
REQ-028 A transaction in flight when rst asserts is dropped; no output pulse follows deassertion.
REQ-029 The first valid transaction after reset behaves identically to any later transaction.

Structure
REQ-030 Package comparator_pkg contains DEFAULT_WIDTH=8 and the typedef cmp_result_e {CMP_LT, CMP_EQ, CMP_GT}.
REQ-031 Sub-module comparator_core is purely combinational and computes the cmp_result_e value and the absolute difference from (a, b, is_signed).
REQ-032 The top-level comparator contains only the input qualification, the output registers and the one-hot decode of cmp_result_e.

Verification (WIDTH=8)
REQ-033 Reset: rst=1 for 2 cycles -> out_valid=0, lt=eq=gt=0, diff=0.
REQ-034 Unsigned: a=0x05, b=0x0A, is_signed=0 -> one cycle later, lt=1, eq=0, gt=0, diff=0x05, out_valid=1.
REQ-035 Signed versus unsigned on the same operands, a=0xFF, b=0x01:
- is_signed=0 -> gt=1, diff=0xFE.
- is_signed=1 -> lt=1, diff=0x02.
REQ-036 Extremes, a=0x80, b=0x7F, is_signed=1 -> lt=1, diff=0xFF.
- Same operands with is_signed=0 -> gt=1, diff=0x01.
REQ-037 Equal and hold: a=b=0x3C with in_valid=1 for 1 cycle, then in_valid=0 for 3 cycles.
- Response: eq=1, diff=0 for all 4 result cycles.
- out_valid pulses high for 1 cycle only.
REQ-038 Back-to-back plus reset:
- Stimulus: 25 consecutive random valid pairs, with rst asserted in the cycle of pair 10.
- Response: results match the reference model one cycle later.
- Pair 10 produces no out_valid; the flags are 0 in the cycle after reset.
- The flags are one-hot on every out_valid.
